// File: rtl/shift32_seq.sv
// shift32_seq: multi-cycle logical shifter with a START/BUSY/DONE handshake.
// Operands are captured on an accepted START; the working register is then
// shifted a little per clock until the captured amount is used up.
// Amounts of 0 or >= 32 finish in a single cycle.
// Optional build macro SHIFT32_SEQ_FAST_EN: shift 4 bits per cycle while at
// least 4 remain, which shortens latency. Results and handshake are unchanged.
//
// Handshake: START is sampled on a CLK rise only while BUSY=0 (IDLE or DONE_ST).
// BUSY=1 for every cycle in SHIFT. DONE=1 for exactly one cycle (DONE_ST),
// and in that cycle Y already holds the new result. Y is otherwise held.
module shift32_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] D,
  input  logic [31:0] S,
  input  logic        LnR,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] Y,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DONE_ST = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] work_q;
  logic [5:0]  cnt_q;       // remaining amount; amounts >= 32 are stored as 32
  logic        dir_q;       // 1 = left, 0 = right
  logic [31:0] y_q;

  logic        accept;
  logic        fin;
  logic [5:0]  step;
  logic [31:0] res;

  assign accept = (state_q != SHIFT) && START;

  // Shift datapath for the current SHIFT cycle: result and whether this is the last edge
  always_comb begin
    step = 6'd1;
    res  = work_q;
    fin  = 1'b0;
    if (cnt_q >= 6'd32) begin
      res = 32'd0;
      fin = 1'b1;
    end else if (cnt_q == 6'd0) begin
      res = work_q;
      fin = 1'b1;
    end else begin
`ifdef SHIFT32_SEQ_FAST_EN
      step = (cnt_q >= 6'd4) ? 6'd4 : 6'd1;
`else
      step = 6'd1;
`endif
      res = dir_q ? (work_q << step) : (work_q >> step);
      fin = (cnt_q == step);
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = START ? SHIFT : IDLE;
      SHIFT:   state_d = fin ? DONE_ST : SHIFT;
      DONE_ST: state_d = START ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    case (state_q)
      SHIFT:   BUSY = 1'b1;
      DONE_ST: DONE = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, shifting and result update
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      work_q <= 32'd0;
      cnt_q  <= 6'd0;
      dir_q  <= 1'b0;
      y_q    <= 32'd0;
    end else if (accept) begin
      work_q <= D;
      cnt_q  <= (S >= 32'd32) ? 6'd32 : S[5:0];
      dir_q  <= LnR;
    end else if (state_q == SHIFT) begin
      work_q <= res;
      if (fin) begin
        cnt_q <= 6'd0;
        y_q   <= res;
      end else begin
        cnt_q <= cnt_q - step;
      end
    end
  end

  assign Y           = y_q;
  assign dbg_state_o = state_q;

endmodule
